// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Round-robin arbiter sharing one resource between NUM_REQ requesters.
//   The grant is registered and strictly one-hot (all-zero when idle). An
//   owner keeps its grant while it holds req, for at most MAX_HOLD cycles;
//   after that, priority rotates past it.
//
//   clk          in   1                 clock, rising edge
//   rst_n        in   1                 asynchronous active-low reset
//   req          in   NUM_REQ           level request per requester
//   grant        out  NUM_REQ           registered one-hot grant, 0 when idle
//   grant_valid  out  1                 |grant
//   grant_id     out  $clog2(NUM_REQ)   binary index of owner, 0 when idle
//   hold_expired out  1                 1-cycle pulse when MAX_HOLD forces rotation
module rr_grant_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       hold_expired
);

  localparam int unsigned IW    = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(MAX_HOLD + 1);
  localparam int unsigned BOUND = (NUM_REQ - 1) * MAX_HOLD + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   owner, owner_d;
  logic [CW-1:0]   hold_cnt, hold_cnt_d;
  logic [NUM_REQ-1:0] grant_d;
  logic            hold_expired_d;

  logic [IW-1:0]   owner_next;
  logic [IW-1:0]   base;
  logic            found;
  logic [IW-1:0]   sel;

  // First set bit of r, searching base, base+1, ... modulo NUM_REQ.
  function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] r,
                                       input logic [IW-1:0]      b);
    logic          f;
    logic [IW-1:0] s;
    int unsigned   idx;
    f = 1'b0;
    s = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(b) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!f && r[idx]) begin
        f = 1'b1;
        s = IW'(idx);
      end
    end
    return {f, s};
  endfunction

  assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // One search serves both cases: from ptr when idle, and from the slot after
  // the current owner when it releases or expires (ptr_d takes that value).
  assign base         = (state == IDLE) ? ptr : owner_next;
  assign {found, sel} = pick(req, base);

  always_comb begin
    state_d        = state;
    ptr_d          = ptr;
    owner_d        = owner;
    hold_cnt_d     = hold_cnt;
    grant_d        = grant;
    hold_expired_d = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          owner_d    = sel;
          grant_d    = '0;
          grant_d[sel] = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (req[owner] && (hold_cnt < CW'(MAX_HOLD - 1))) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end else begin
          // Release wins over a coincident expiry: pulse only if req still held.
          hold_expired_d = req[owner];
          ptr_d          = owner_next;
          hold_cnt_d     = '0;
          grant_d        = '0;
          if (found) begin
            owner_d      = sel;
            grant_d[sel] = 1'b1;
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      hold_cnt     <= '0;
      grant        <= '0;
      hold_expired <= 1'b0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      owner        <= owner_d;
      hold_cnt     <= hold_cnt_d;
      grant        <= grant_d;
      hold_expired <= hold_expired_d;
    end
  end

  assign grant_valid = |grant;
  assign grant_id    = owner;

  // Invariants.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
  a_id_set: assert property (@(posedge clk) disable iff (!rst_n) grant_valid |-> grant[grant_id]);
  a_id_0:   assert property (@(posedge clk) disable iff (!rst_n) !grant_valid |-> grant_id == '0);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    logic [15:0] wait_cnt;

    // Cycles requester i has been holding req without being granted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  wait_cnt <= '0;
      else if (!req[i] || grant[i]) wait_cnt <= '0;
      else if (wait_cnt != '1)     wait_cnt <= wait_cnt + 1'b1;
    end

    a_rose: assert property (@(posedge clk) disable iff (!rst_n)
                             $rose(grant[i]) |-> $past(req[i]));
    a_wait: assert property (@(posedge clk) disable iff (!rst_n)
                             wait_cnt <= 16'(BOUND));
  end

endmodule
